e2b_conv_arbiter: RTL and testbench

//  Shares one excess-3 to BCD converter core among NREQ requesters.

---
 rtl/e2b_pkg.sv | 15 +
 rtl/e2b_core.sv | 14 +
 rtl/e2b_conv_arbiter.sv | 153 +++++++++++++++
 tb/tb_e2b_conv_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e2b_pkg.sv
// Shared definitions for the excess-3 to BCD converter arbiter:
// FSM state encoding and the valid excess-3 code range.
package e2b_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  // Excess-3 digits 0..9 are encoded as 3..12
  localparam logic [3:0] E3_MIN = 4'd3;
  localparam logic [3:0] E3_MAX = 4'd12;

endpackage

// File: rtl/e2b_core.sv
// Combinational excess-3 to BCD digit converter.
// Codes outside 3..12 are flagged and produce a zero digit.
module e2b_core
  import e2b_pkg::*;
(
  input  logic [3:0] e_i,
  output logic [3:0] b_o,
  output logic       err_o
);

  assign err_o = (e_i < E3_MIN) || (e_i > E3_MAX);
  assign b_o   = err_o ? 4'd0 : (e_i - E3_MIN);

endmodule

// File: rtl/e2b_conv_arbiter.sv
// Round-robin arbiter sharing one excess-3 to BCD converter among NREQ
// requesters. One conversion is in flight at a time:
// IDLE (grant + capture) -> CONV (register result) -> HOLD (wait for ready).
module e2b_conv_arbiter
  import e2b_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] e_in,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_b,
  output logic [IDW-1:0]    out_id,
  output logic              out_err,
  output logic              busy,
  output logic [CNTW-1:0]   conv_cnt,
  output logic [CNTW-1:0]   err_cnt
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [3:0]       e_q, e_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             ov_q, ov_d;
  logic [3:0]       ob_q, ob_d;
  logic [IDW-1:0]   oid_q, oid_d;
  logic             oerr_q, oerr_d;
  logic [CNTW-1:0]  conv_q, conv_d;
  logic [CNTW-1:0]  errc_q, errc_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [3:0]       e_sel;
  logic [3:0]       core_b;
  logic             core_err;

  // Counters hold at all-ones instead of wrapping
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  e2b_core u_core (
    .e_i   (e_q),
    .b_o   (core_b),
    .err_o (core_err)
  );

  // Round-robin pick: first request at or above ptr, else lowest request below it
  always_comb begin
    found = 1'b0;
    pick  = '0;
    e_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr_q))) begin
        found = 1'b1;
        pick  = IDW'(j);
        e_sel = e_in[4*j +: 4];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
        e_sel = e_in[4*j +: 4];
      end
    end
  end

  // Grant only while idle and out of reset, so a held request never sees gnt during reset
  assign gnt = (rst_n && (state_q == ST_IDLE) && found) ? (NREQ'(1) << pick) : '0;

  // Next-state logic for the FSM, capture registers, output registers and counters
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    e_d     = e_q;
    id_d    = id_q;
    ov_d    = ov_q;
    ob_d    = ob_q;
    oid_d   = oid_q;
    oerr_d  = oerr_q;
    conv_d  = conv_q;
    errc_d  = errc_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          e_d     = e_sel;
          id_d    = pick;
          ptr_d   = (pick == IDW'(NREQ-1)) ? '0 : pick + 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        ob_d    = core_b;
        oerr_d  = core_err;
        oid_d   = id_q;
        ov_d    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          conv_d  = sat_inc(conv_q);
          if (oerr_q) errc_d = sat_inc(errc_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      e_q     <= '0;
      id_q    <= '0;
      ov_q    <= 1'b0;
      ob_q    <= '0;
      oid_q   <= '0;
      oerr_q  <= 1'b0;
      conv_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      e_q     <= e_d;
      id_q    <= id_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      oid_q   <= oid_d;
      oerr_q  <= oerr_d;
      conv_q  <= conv_d;
      errc_q  <= errc_d;
    end
  end

  assign out_valid = ov_q;
  assign out_b     = ob_q;
  assign out_id    = oid_q;
  assign out_err   = oerr_q;
  assign busy      = (state_q != ST_IDLE);
  assign conv_cnt  = conv_q;
  assign err_cnt   = errc_q;

endmodule

// File: tb/tb_e2b_conv_arbiter.sv
// Directed testbench for e2b_conv_arbiter: reset, single conversions,
// invalid codes, round-robin fairness, back-pressure, mid-operation reset,
// all codes on every requester, and counter saturation.
module tb_e2b_conv_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] e_in;
  logic              out_ready;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic [3:0]        out_b;
  logic [IDW-1:0]    out_id;
  logic              out_err;
  logic              busy;
  logic [CNTW-1:0]   conv_cnt;
  logic [CNTW-1:0]   err_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  e2b_conv_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .e_in      (e_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_id    (out_id),
    .out_err   (out_err),
    .busy      (busy),
    .conv_cnt  (conv_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/gnt"},       32'(gnt),       0);
    chk({tag, "/out_valid"}, 32'(out_valid), 0);
    chk({tag, "/out_b"},     32'(out_b),     0);
    chk({tag, "/out_id"},    32'(out_id),    0);
    chk({tag, "/out_err"},   32'(out_err),   0);
    chk({tag, "/busy"},      32'(busy),      0);
    chk({tag, "/conv_cnt"},  32'(conv_cnt),  0);
    chk({tag, "/err_cnt"},   32'(err_cnt),   0);
  endtask

  task automatic chk_result(input string tag, input int b, input int id, input int err);
    chk({tag, "/out_valid"}, 32'(out_valid), 1);
    chk({tag, "/out_b"},     32'(out_b),     b);
    chk({tag, "/out_id"},    32'(out_id),    id);
    chk({tag, "/out_err"},   32'(out_err),   err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int ord_a[5];
    int ord_b[2];
    int exp_b;
    int exp_err;
    ord_a = '{0, 1, 2, 3, 0};
    ord_b = '{3, 0};

    // 1: reset with random inputs, then idle with no requests
    rst_n     = 1'b0;
    req       = 4'($urandom);
    e_in      = 16'($urandom);
    out_ready = 1'($urandom);
    #2;
    chk_zero("t1_rst_a");
    tick();
    req = 4'($urandom) | 4'b0001;
    settle();
    chk_zero("t1_rst_b");
    rst_n     = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_idle_gnt",  32'(gnt),  0);
    end

    // 2: single conversion on requester 1, code 5 -> digit 2
    e_in      = '0;
    e_in[7:4] = 4'b0101;
    req       = 4'b0010;
    settle();
    chk("t2_gnt", 32'(gnt), 32'h2);
    tick();
    req = '0;
    settle();
    chk("t2_gnt_once", 32'(gnt),       0);
    chk("t2_busy",     32'(busy),      1);
    chk("t2_nvalid",   32'(out_valid), 0);
    tick();
    chk_result("t2_res", 2, 1, 0);
    out_ready = 1'b1;
    tick();
    chk("t2_acc_valid", 32'(out_valid), 0);
    chk("t2_acc_busy",  32'(busy),      0);
    chk("t2_conv_cnt",  32'(conv_cnt),  1);
    chk("t2_err_cnt",   32'(err_cnt),   0);

    // 3: invalid code 1 on requester 0
    out_ready = 1'b0;
    do_reset();
    e_in[3:0] = 4'b0001;
    req       = 4'b0001;
    settle();
    chk("t3_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    chk_result("t3_res", 0, 0, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_acc_valid", 32'(out_valid), 0);
    chk("t3_conv_cnt",  32'(conv_cnt),  1);
    chk("t3_err_cnt",   32'(err_cnt),   1);

    // 4: all four requesting, then requesters 3 and 0 from ptr=1
    do_reset();
    out_ready = 1'b1;
    e_in      = {4'd12, 4'd9, 4'd6, 4'd3};
    req       = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t4_gnt", 32'(gnt), 32'(1 << ord_a[k]));
      tick();
      tick();
      chk_result("t4_res", 3 * ord_a[k], ord_a[k], 0);
      tick();
    end
    req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t4_wrap_gnt", 32'(gnt), 32'(1 << ord_b[k]));
      tick();
      tick();
      chk_result("t4_wrap_res", 3 * ord_b[k], ord_b[k], 0);
      tick();
    end
    req = '0;
    settle();
    chk("t4_conv_cnt", 32'(conv_cnt), 7);
    chk("t4_err_cnt",  32'(err_cnt),  0);

    // 5: back-pressure on requester 2, code 7 -> digit 4, others waiting
    out_ready  = 1'b0;
    e_in[11:8] = 4'd7;
    req        = 4'b0100;
    settle();
    chk("t5_gnt", 32'(gnt), 32'h4);
    tick();
    e_in[3:0] = 4'd8;
    req       = 4'b0011;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_result("t5_hold", 4, 2, 0);
      chk("t5_hold_gnt", 32'(gnt), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t5_acc_valid", 32'(out_valid), 0);
    chk("t5_acc_busy",  32'(busy),      0);
    chk("t5_conv_cnt",  32'(conv_cnt),  8);
    chk("t5_next_gnt",  32'(gnt),       32'h1);

    // 6: reset during CONV, pending request re-granted from ptr=0
    tick();
    chk("t6_busy", 32'(busy), 1);
    rst_n = 1'b0;
    settle();
    chk_zero("t6_rst_a");
    tick();
    chk_zero("t6_rst_b");
    rst_n = 1'b1;
    settle();
    chk("t6_regnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    chk_result("t6_res", 5, 0, 0);
    tick();
    chk("t6_conv_cnt", 32'(conv_cnt), 1);

    // Every code on every requester
    out_ready = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      for (int e = 0; e < 16; e++) begin
        e_in[4*r +: 4] = 4'(e);
        req            = 4'(1 << r);
        exp_err        = (e < 3 || e > 12) ? 1 : 0;
        exp_b          = exp_err ? 0 : e - 3;
        settle();
        chk("ex_gnt", 32'(gnt), 32'(1 << r));
        tick();
        req = '0;
        tick();
        chk_result("ex_res", exp_b, r, exp_err);
        tick();
      end
    end

    // Counter saturation with a persistent requester sending invalid codes
    do_reset();
    out_ready = 1'b1;
    e_in      = '0;
    req       = 4'b0001;
    repeat (254 * 3) tick();
    chk("sat_conv_254", 32'(conv_cnt), 254);
    chk("sat_err_254",  32'(err_cnt),  254);
    repeat (6 * 3) tick();
    req = '0;
    chk("sat_conv_max", 32'(conv_cnt), 255);
    chk("sat_err_max",  32'(err_cnt),  255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
